// File: rtl/bob_retire_ctl.sv
// bob_retire_ctl: retire-side consumer of the branch order buffer.
//
// Watches has_retire/retire_addr, issues the RAM read (registered-address
// RAM, data one cycle later), pulses do_retire to advance the BOB retire
// pointer, and hands retired entries to commit through a 2-entry queue
// with a valid/ready handshake. Owns flush recovery after an exception.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   except       exception flush (same cycle as the BOB address flush)
//   has_retire   entry at retire_addr is valid
//   retire_addr  current retire index
//   do_retire    consume entry; retire pointer advances next cycle
//   ram_clkEn    RAM read-address latch enable
//   ram_addr     RAM read address (always retire_addr)
//   ram_data     RAM read data, valid the cycle after ram_clkEn
//   out_valid    retired entry available
//   out_ready    commit accepts the entry
//   out_data     retired entry
//   out_addr     BOB index of out_data
//   retired_cnt  count of accepted entries, wraps at 16 bits
//
// Optional feature: define BOB_RETIRE_BYPASS_EN to forward arriving RAM data
// straight to the output when the queue is empty (latency N+1 instead of
// N+2). Undefined, every entry passes through the queue registers.

`ifndef BOB_WIDTH
`define BOB_WIDTH 32
`endif

module bob_retire_ctl #(
  parameter int unsigned DATA_WIDTH = `BOB_WIDTH,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  except,
  input  logic                  has_retire,
  input  logic [ADDR_WIDTH-1:0] retire_addr,
  output logic                  do_retire,
  output logic                  ram_clkEn,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [15:0]           retired_cnt
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t state, state_nxt;

  // A read returns exactly one cycle after issue and at most one read is
  // issued per cycle, so the in-flight count never exceeds one entry.
  logic                  infl;
  logic [ADDR_WIDTH-1:0] infl_tag;

  logic [1:0]            occ;
  logic                  wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] q_data [2];
  logic [ADDR_WIDTH-1:0] q_addr [2];

  logic byp, pop, q_pop, push, issue;

  always_comb begin
    state_nxt = state;
    if (except) state_nxt = FLUSH;
    else        state_nxt = RUN;
  end

  always_comb begin
    byp = 1'b0;
`ifdef BOB_RETIRE_BYPASS_EN
    byp = (occ == 2'd0) && (state == RUN) && !except && infl;
`endif
    if (byp) begin
      out_valid = 1'b1;
      out_data  = ram_data;
      out_addr  = infl_tag;
    end else begin
      out_valid = (occ != 2'd0);
      out_data  = q_data[rd_ptr];
      out_addr  = q_addr[rd_ptr];
    end
    pop   = out_valid & out_ready;
    q_pop = pop & !byp;
    // A bypassed entry taken this cycle never enters the queue.
    push  = infl & !(byp & out_ready);
    // Total outstanding (queued + in flight) is capped at two; a pop this
    // cycle frees a slot for the read being issued now. rst gates the
    // combinational strobes so they read 0 while reset is held.
    issue = rst && (state == RUN) && has_retire && !except &&
            (({1'b0, occ} + {2'b0, infl}) <= (3'd1 + {2'b0, pop}));
  end

  assign do_retire = issue;
  assign ram_clkEn = issue;
  assign ram_addr  = retire_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      infl        <= 1'b0;
      infl_tag    <= '0;
      occ         <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      retired_cnt <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        q_data[i] <= '0;
        q_addr[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (pop) retired_cnt <= retired_cnt + 16'd1;
      // issue is never set in an except cycle, so this also clears infl.
      infl <= issue;
      if (issue) infl_tag <= retire_addr;
      if (except) begin
        // Queued entries and data arriving this cycle are dropped.
        occ    <= '0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) begin
          q_data[wr_ptr] <= ram_data;
          q_addr[wr_ptr] <= infl_tag;
          wr_ptr         <= ~wr_ptr;
        end
        if (q_pop) rd_ptr <= ~rd_ptr;
        occ <= occ + {1'b0, push} - {1'b0, q_pop};
      end
    end
  end

endmodule
